// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS controller
package mc_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes (zero-extended to the configured width at the port)
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11,
        S_FAULT    = 4'd15
    } state_t;

    // ALU operation for the immediate-arithmetic opcodes
    function automatic logic [2:0] imm_alu_code(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_control_if #(
    parameter int ALUCTL_W = 3
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUCTL_W-1:0] alu_control;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                retire;
    logic                illegal;
    logic                fault;
    logic [3:0]          state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
               reg_write, retire, illegal, fault, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
               reg_write, retire, illegal, fault, state
    );
endinterface

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - R-type funct to ALU control decode with legality flag
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_legal
);

    // Map funct to ALU op; unknown functs report not-legal and fall back to add
    always_comb begin
        o_alu_control = ALU_ADD;
        o_legal       = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_control = ALU_ADD;
            FN_SUB:  o_alu_control = ALU_SUB;
            FN_AND:  o_alu_control = ALU_AND;
            FN_OR:   o_alu_control = ALU_OR;
            FN_SLT:  o_alu_control = ALU_SLT;
            default: o_legal       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM; MULTICYCLE_CONTROL_IMM_EN enables immediate ALU ops
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 3,
    parameter int WAIT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    // Counter value at which one more unanswered request cycle hits 2^WAIT_W-1
    localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_fault;

    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_iord;
    logic              w_ir_write;
    logic              w_pc_write;
    logic [1:0]        w_pc_src;
    logic              w_alu_src_a;
    logic [1:0]        w_alu_src_b;
    logic [2:0]        w_alu;
    logic              w_reg_dst;
    logic              w_mem_to_reg;
    logic              w_reg_write;
    logic              w_retire;
    logic              w_set_illegal;
    logic              w_timeout;
    logic [2:0]        w_fn_alu;
    logic              w_fn_legal;

    mc_alu_decode u_alu_decode (
        .i_funct       (bus.funct),
        .o_alu_control (w_fn_alu),
        .o_legal       (w_fn_legal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory wait counter: counts unanswered request cycles, restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_mem_req && !bus.mem_ready) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_timeout)     r_fault   <= 1'b1;
        end
    end

    // Next-state and control outputs; the timeout overrides whatever the state chose
    always_comb begin
        w_next        = r_state;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_iord        = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = PCSRC_ALU;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = SRCB_RT;
        w_alu         = ALU_ADD;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_timeout     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here
                w_alu_src_b = SRCB_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_RTYPE:       w_next = S_EXEC;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
`ifdef MULTICYCLE_CONTROL_IMM_EN
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IMM_EXEC;
`endif
                    default: begin
                        w_set_illegal = 1'b1;
                        w_next        = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_next      = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu       = w_fn_alu;
                if (w_fn_legal) begin
                    w_next = S_ALU_WB;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu       = ALU_SUB;
                w_pc_src    = PCSRC_ALUOUT;
                w_pc_write  = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                              ((bus.opcode == OP_BNE) && !bus.zero);
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
`ifdef MULTICYCLE_CONTROL_IMM_EN
            S_IMM_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_alu       = imm_alu_code(bus.opcode);
                w_next      = S_IMM_WB;
            end
            S_IMM_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
`endif
            S_FAULT: begin
                w_alu = 3'b000;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // A ready in the limit cycle completes the request instead of faulting
        if (w_mem_req && !bus.mem_ready && (r_wait == WAIT_LAST)) begin
            w_timeout = 1'b1;
            w_next    = S_FAULT;
        end
    end

    // Outputs are held low while reset is high so a pending request drops immediately
    assign bus.mem_req     = !reset && w_mem_req;
    assign bus.mem_we      = !reset && w_mem_we;
    assign bus.iord        = !reset && w_iord;
    assign bus.ir_write    = !reset && w_ir_write;
    assign bus.pc_write    = !reset && w_pc_write;
    assign bus.pc_src      = reset ? 2'b00 : w_pc_src;
    assign bus.alu_src_a   = !reset && w_alu_src_a;
    assign bus.alu_src_b   = reset ? 2'b00 : w_alu_src_b;
    assign bus.alu_control = reset ? '0 : ALUCTL_W'(w_alu);
    assign bus.reg_dst     = !reset && w_reg_dst;
    assign bus.mem_to_reg  = !reset && w_mem_to_reg;
    assign bus.reg_write   = !reset && w_reg_write;
    assign bus.retire      = !reset && w_retire;
    assign bus.illegal     = !reset && r_illegal;
    assign bus.fault       = !reset && r_fault;
    assign bus.state       = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic clk;
    logic reset;

    multicycle_control_if #(.ALUCTL_W(3)) bus ();

    multicycle_control #(.ALUCTL_W(3), .WAIT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [22:0] exp;
        string       tag;
    } cyc_t;

    cyc_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic ill_s = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] pk(
        input logic [3:0] st, input logic req, input logic we, input logic iord,
        input logic irw, input logic pcw, input logic [1:0] pcs, input logic sa,
        input logic [1:0] sb, input logic [2:0] alu, input logic rd, input logic m2r,
        input logic rw, input logic ret, input logic ill, input logic flt);
        return {st, req, we, iord, irw, pcw, pcs, sa, sb, alu, rd, m2r, rw, ret, ill, flt};
    endfunction

    // Expected output vectors per state, written out from the control table
    function automatic logic [22:0] e_rst();
        return '0;
    endfunction
    function automatic logic [22:0] e_fetch(input logic rdy);
        return pk(4'd0, 1, 0, 0, rdy, rdy, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_dec();
        return pk(4'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, 0, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_maddr();
        return pk(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_mrd();
        return pk(4'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_mwb();
        return pk(4'd4, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 1, 1, 1, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_mwr(input logic rdy);
        return pk(4'd5, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, rdy, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_exec(input logic [2:0] alu);
        return pk(4'd6, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, alu, 0, 0, 0, 0, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_awb();
        return pk(4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1, 0, 1, 1, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_br(input logic pcw);
        return pk(4'd8, 0, 0, 0, 0, pcw, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 1, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_jmp();
        return pk(4'd9, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 0, 0, 1, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_iex(input logic [2:0] alu);
        return pk(4'd10, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, alu, 0, 0, 0, 0, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_iwb();
        return pk(4'd11, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 1, 1, ill_s, 0);
    endfunction
    function automatic logic [22:0] e_fault();
        return pk(4'd15, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, ill_s, 1);
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [22:0] exp, input string tag);
        cyc_t c;
        c.rst = rst; c.op = op; c.fn = fn; c.z = z; c.rdy = rdy; c.exp = exp; c.tag = tag;
        q.push_back(c);
    endtask

    function automatic logic [22:0] observed();
        return pk(bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                  bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.reg_dst,
                  bus.mem_to_reg, bus.reg_write, bus.retire, bus.illegal, bus.fault);
    endfunction

    // Apply each cycle's inputs after the falling edge, compare mid-cycle
    task automatic drain();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            reset         = c.rst;
            bus.opcode    = c.op;
            bus.funct     = c.fn;
            bus.zero      = c.z;
            bus.mem_ready = c.rdy;
            #1;
            check_eq(c.tag, {9'd0, observed()}, {9'd0, c.exp});
            @(negedge clk);
        end
    endtask

    task automatic r_type(input logic [5:0] fn, input logic [2:0] alu, input string tag);
        push(0, OP_RTYPE, fn, 0, 1, e_fetch(1), {tag, "_fetch"});
        push(0, OP_RTYPE, fn, 0, 1, e_dec(), {tag, "_dec"});
        push(0, OP_RTYPE, fn, 0, 1, e_exec(alu), {tag, "_exec"});
        push(0, OP_RTYPE, fn, 0, 1, e_awb(), {tag, "_wb"});
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic pcw, input string tag);
        push(0, op, 6'd0, z, 1, e_fetch(1), {tag, "_fetch"});
        push(0, op, 6'd0, z, 1, e_dec(), {tag, "_dec"});
        push(0, op, 6'd0, z, 1, e_br(pcw), {tag, "_br"});
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);

        push(1, OP_LW, 6'd0, 0, 1, e_rst(), "reset0");
        push(1, OP_LW, 6'd0, 0, 1, e_rst(), "reset1");

        // lw, zero-wait memory: 5 cycles
        push(0, OP_LW, 6'd0, 0, 1, e_fetch(1), "lw_fetch");
        push(0, OP_LW, 6'd0, 0, 1, e_dec(), "lw_dec");
        push(0, OP_LW, 6'd0, 0, 1, e_maddr(), "lw_addr");
        push(0, OP_LW, 6'd0, 0, 1, e_mrd(), "lw_rd");
        push(0, OP_LW, 6'd0, 0, 1, e_mwb(), "lw_wb");

        // sw with three stall cycles in MEM_WR
        push(0, OP_SW, 6'd0, 0, 1, e_fetch(1), "sw_fetch");
        push(0, OP_SW, 6'd0, 0, 1, e_dec(), "sw_dec");
        push(0, OP_SW, 6'd0, 0, 1, e_maddr(), "sw_addr");
        for (int i = 0; i < 3; i++) push(0, OP_SW, 6'd0, 0, 0, e_mwr(0), "sw_stall");
        push(0, OP_SW, 6'd0, 0, 1, e_mwr(1), "sw_done");

        branch(OP_BEQ, 1, 1, "beq_z1");
        branch(OP_BEQ, 0, 0, "beq_z0");
        branch(OP_BNE, 1, 0, "bne_z1");
        branch(OP_BNE, 0, 1, "bne_z0");

        r_type(FN_SLT, ALU_SLT, "slt");
        r_type(FN_SUB, ALU_SUB, "sub");
        r_type(FN_AND, ALU_AND, "and");
        r_type(FN_OR,  ALU_OR,  "or");
        r_type(FN_ADD, ALU_ADD, "add");

        push(0, OP_J, 6'd0, 0, 1, e_fetch(1), "j_fetch");
        push(0, OP_J, 6'd0, 0, 1, e_dec(), "j_dec");
        push(0, OP_J, 6'd0, 0, 1, e_jmp(), "j_jump");

`ifdef MULTICYCLE_CONTROL_IMM_EN
        push(0, OP_ADDI, 6'd0, 0, 1, e_fetch(1), "addi_fetch");
        push(0, OP_ADDI, 6'd0, 0, 1, e_dec(), "addi_dec");
        push(0, OP_ADDI, 6'd0, 0, 1, e_iex(ALU_ADD), "addi_exec");
        push(0, OP_ADDI, 6'd0, 0, 1, e_iwb(), "addi_wb");
        push(0, OP_SLTI, 6'd0, 0, 1, e_fetch(1), "slti_fetch");
        push(0, OP_SLTI, 6'd0, 0, 1, e_dec(), "slti_dec");
        push(0, OP_SLTI, 6'd0, 0, 1, e_iex(ALU_SLT), "slti_exec");
        push(0, OP_SLTI, 6'd0, 0, 1, e_iwb(), "slti_wb");
`endif

        // Unknown funct: illegal, no writeback
        push(0, OP_RTYPE, 6'b000111, 0, 1, e_fetch(1), "badfn_fetch");
        push(0, OP_RTYPE, 6'b000111, 0, 1, e_dec(), "badfn_dec");
        push(0, OP_RTYPE, 6'b000111, 0, 1, e_exec(ALU_ADD), "badfn_exec");
        ill_s = 1'b1;
        push(0, OP_J, 6'd0, 0, 1, e_fetch(1), "badfn_after");
        push(0, OP_J, 6'd0, 0, 1, e_dec(), "sticky_dec");
        push(0, OP_J, 6'd0, 0, 1, e_jmp(), "sticky_jump");

        // Unknown opcode
        push(0, 6'b111111, 6'd0, 0, 1, e_fetch(1), "badop_fetch");
        push(0, 6'b111111, 6'd0, 0, 1, e_dec(), "badop_dec");
`ifndef MULTICYCLE_CONTROL_IMM_EN
        push(0, OP_ADDI, 6'd0, 0, 1, e_fetch(1), "addi_off_fetch");
        push(0, OP_ADDI, 6'd0, 0, 1, e_dec(), "addi_off_dec");
`endif

        // Reset in MEM_RD abandons the load and clears the sticky flag
        push(0, OP_LW, 6'd0, 0, 1, e_fetch(1), "rstrd_fetch");
        push(0, OP_LW, 6'd0, 0, 1, e_dec(), "rstrd_dec");
        push(0, OP_LW, 6'd0, 0, 1, e_maddr(), "rstrd_addr");
        push(0, OP_LW, 6'd0, 0, 0, e_mrd(), "rstrd_rd");
        push(1, OP_LW, 6'd0, 0, 0, e_rst(), "rstrd_reset");
        ill_s = 1'b0;

        // Ready arriving on the limit cycle wins over the timeout
        for (int i = 0; i < 14; i++) push(0, OP_J, 6'd0, 0, 0, e_fetch(0), "limit_wait");
        push(0, OP_J, 6'd0, 0, 1, e_fetch(1), "limit_ready");
        push(0, OP_J, 6'd0, 0, 1, e_dec(), "limit_dec");
        push(0, OP_J, 6'd0, 0, 1, e_jmp(), "limit_jump");

        // Hung memory: fault after 15 unanswered fetch cycles
        for (int i = 0; i < 15; i++) push(0, OP_J, 6'd0, 0, 0, e_fetch(0), "hang_wait");
        push(0, OP_J, 6'd0, 0, 0, e_fault(), "fault_enter");
        push(0, OP_J, 6'd0, 0, 1, e_fault(), "fault_hold");
        push(1, OP_J, 6'd0, 0, 1, e_rst(), "fault_reset");
        push(0, OP_J, 6'd0, 0, 0, e_fetch(0), "fault_cleared");

        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle MIPS controller. It replaces the single-cycle opcode/funct decode with a Moore/Mealy state machine that sequences fetch, decode, execute, memory and writeback over several cycles, using one shared memory port with a ready handshake. It sits between the instruction register and the datapath muxes, ALU, register file and memory. Widths are parametrised, memory stalls are tolerated, and a watchdog traps a hung memory.

Parameters:
ALUCTL_W, 3, ALU control width; codes are zero-extended when wider than 3.
WAIT_W, 4, memory-wait counter width; timeout occurs after 2^WAIT_W-1 unanswered request cycles.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], stable after DECODE
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write strobe, valid with mem_req
iord  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_control  out  ALUCTL_W  add 010, sub 110, and 000, or 001, slt 111
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  writeback from MDR
reg_write  out  1  register file write
retire  out  1  one-cycle pulse on instruction completion
illegal  out  1  sticky: unknown opcode or funct seen
fault  out  1  sticky: memory timeout
state  out  4  current state, for debug

Behaviour:
- Reset:
  - state=FETCH, wait counter=0, illegal=0, fault=0.
  - While reset is high, all outputs are forced 0, including mem_req.
  - Reset asserted mid-operation abandons the instruction; mem_req drops in the same cycle.
- Default values for every output in every state: 0 / add.
- FETCH(0): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise hold.
- DECODE(1): alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Dispatch:
  - lw 100011 / sw 101011 -> MEM_ADDR
  - R 000000 -> EXEC
  - beq 000100 / bne 000101 -> BRANCH
  - j 000010 -> JUMP
  - immediate ops -> IMM_EXEC (only with the optional feature)
  - anything else -> set illegal, go to FETCH (treated as nop, no retire)
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, add. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD(3): mem_req=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, retire. Go to FETCH.
- MEM_WR(5): mem_req=1, mem_we=1, iord=1. On mem_ready: retire, go to FETCH.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_control decoded from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Other funct: set illegal, go to FETCH, no retire.
  - Legal funct: go to ALU_WB.
- ALU_WB(7): reg_write=1, reg_dst=1, retire. Go to FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_write = (beq & zero) | (bne & ~zero) (Mealy on zero).
  - retire, go to FETCH.
- JUMP(9): pc_src=10, pc_write=1, retire. Go to FETCH.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Clears on any state change.
  - On reaching 2^WAIT_W-1: set fault, enter FAULT(15).
  - If mem_ready arrives in the same cycle the limit is reached, mem_ready wins.
- FAULT(15): all outputs 0. Left only by reset.
- Latencies with zero-wait memory: lw 5, sw 4, R-type 4, beq/bne 3, j 3 cycles.

Optional Feature:
MULTICYCLE_CONTROL_IMM_EN
- Enabled: addi 001000, andi 001100, ori 001101, slti 001010 are decoded.
  - IMM_EXEC(10): alu_src_a=1, alu_src_b=10, op = add/and/or/slt.
  - IMM_WB(11): reg_write=1, reg_dst=0, retire. Go to FETCH.
  - Latency 4 cycles.
- Disabled: these opcodes set illegal. States 10 and 11 are never entered.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode and funct localparams
  - state enum with the encodings above
  - ALU control code constants
  - pc_src and alu_src_b encodings
- One sub-module, mc_alu_decode: combinational funct -> {alu_control, legal}, reused by EXEC.

Test Plan:
- lw, mem_ready held 1 -> states 0,1,2,3,4; reg_write=1 and mem_to_reg=1 in cycle 5; retire exactly once.
- sw with mem_ready low for 3 cycles in MEM_WR -> mem_req and mem_we held for 4 cycles; no fault; retire on the ready cycle.
- beq with zero=1 then zero=0; bne likewise -> pc_write=1 only for beq/zero=1 and bne/zero=0; pc_src=01.
- R-type with funct 101010 -> alu_control=111 in EXEC; funct 000111 -> illegal=1, no reg_write, back to FETCH.
- mem_ready held 0 in FETCH with WAIT_W=4 -> fault=1 after 15 cycles; reset then returns to FETCH and clears fault.
- Reset asserted during MEM_RD -> mem_req=0 that cycle, state=FETCH next; with IMM_EN, addi -> alu_src_b=10, add, reg_write in cycle 4.
